jk_bank_arbiter: RTL and testbench
==================================

Name: jk_bank_arbiter

Overview:
Shares one bank of NUM_FF JK flip-flops between NUM_REQ requesters.
Each requester issues single-bit JK commands (hold/reset/set/toggle) to an addressed flip-flop over a valid/ready handshake.
A round-robin arbiter picks one winner per slot, and a two-state FSM applies the winning op to the bank.
Sits between control agents and shared status/flag bits built from JK flip-flops.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NUM_FF, 8, number of JK flip-flops in the bank
ADDR_W, 3, flip-flop address width; must satisfy 2**ADDR_W >= NUM_FF

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester command valid
req_addr  input  NUM_REQ*ADDR_W  packed target address; requester i at [i*ADDR_W +: ADDR_W]
req_op  input  NUM_REQ*2  packed {J,K}; requester i at [2i +: 2]
req_ready  output  NUM_REQ  one-hot acknowledge to the winner
q  output  NUM_FF  flip-flop bank state
grant_valid  output  1  high during the APPLY cycle
grant_id  output  $clog2(NUM_REQ)  requester being applied; valid when grant_valid=1
addr_err  output  1  high during APPLY if the captured addr >= NUM_FF

Behaviour:
- Op encoding {J,K}:
  - 00 hold
  - 01 reset (q[a]<=0)
  - 10 set (q[a]<=1)
  - 11 toggle (q[a]<=~q[a])
- Reset values: q=0, req_ready=0, grant_valid=0, grant_id=0, addr_err=0, state=ARB, rr_ptr=0.
- FSM states are ARB and APPLY.
- ARB state:
  - If any req_valid is set, the winner is the first valid requester searching from rr_ptr upward, with wrap-around.
  - req_ready[winner]=1 combinationally in this cycle only.
  - On the clock edge, addr/op/id are captured, rr_ptr <= winner+1 (mod NUM_REQ), and the FSM moves to APPLY.
  - If no request is valid, stay in ARB; rr_ptr unchanged.
- APPLY state (exactly 1 cycle):
  - grant_valid=1; grant_id and addr_err are registered outputs.
  - On the edge ending APPLY, the op is applied to q[addr]; all other bits hold. Then return to ARB.
- Latency: handshake in cycle t → q updated, visible in cycle t+2. Throughput is 1 op per 2 cycles.
- Every op, including hold, consumes a slot.
- Out-of-range addr: the command is acknowledged, addr_err=1 during APPLY, and q is unchanged.
- req_ready is 0 in APPLY. Requesters hold valid/addr/op stable until ready; a request may be withdrawn before ready.
- Handshake completes on req_valid & req_ready. Only one requester is ever acked per slot.
- Back-to-back requests to the same address from different requesters are serialised in grant order, e.g. toggle then toggle leaves q unchanged.
- rst during APPLY: the captured op is discarded and all state returns to reset values on that edge.
- Starvation bound: a continuously valid requester is acked within NUM_REQ slots (2*NUM_REQ cycles).

Optional Feature:
- Macro JKA_OPCOUNT_EN.
- Defined:
  - Adds output op_count [15:0].
  - Increments on each edge ending APPLY with addr_err=0, saturating at 16'hFFFF.
  - Cleared by rst.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package jka_pkg holds:
  - op localparams OP_HOLD=2'b00, OP_RST=2'b01, OP_SET=2'b10, OP_TGL=2'b11
  - state encoding ST_ARB, ST_APPLY
  - the counter width, 16
- One natural sub-module, jk_bank:
  - NUM_FF JK flip-flops with a shared clk/rst.
  - Per-bit J, K and enable inputs; q output.
  - Only the enabled bit updates.
- The arbiter, FSM and capture registers stay in jk_bank_arbiter.

Test Plan:
- Reset release, no requests for 5 cycles → q=8'h00, req_ready=0, grant_valid=0 throughout.
- Req0 set addr 3 at t → req_ready[0]=1 at t; grant_valid=1, grant_id=0 at t+1; q=8'h08 at t+2.
- Req0, req1, req2 and req3 all valid with toggle on addrs 0, 1, 2, 3, held → grants in order 0,1,2,3 every 2 cycles; q=8'h0F after 8 cycles; a fifth slot grants 0 again.
- Req1 set addr 5, then req2 toggle addr 5, then req3 reset addr 5 → q[5] goes 1, 0, 0; hold op on addr 5 → q unchanged, and the slot is still granted.
- Req2 addr 7 with NUM_FF=6 → addr_err=1 during APPLY, q unchanged; with JKA_OPCOUNT_EN, op_count does not increment.
- q=8'hFF, then req0 toggle addr 0 with rst asserted during APPLY → q=8'h00 next cycle, state ARB, rr_ptr=0, no toggle applied afterwards.

Source files
------------

// File: rtl/jka_pkg.sv
// Shared definitions for the JK bank arbiter: op encodings, FSM states and
// the width of the optional op counter.
package jka_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_RST  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  localparam int OPCNT_W = 16;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

endpackage

// File: rtl/jk_bank.sv
// Bank of JK flip-flops with per-bit J/K/enable; only enabled bits update,
// all bits clear on synchronous reset.
module jk_bank #(
  parameter int NUM_FF = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_FF-1:0] j,
  input  logic [NUM_FF-1:0] k,
  input  logic [NUM_FF-1:0] en,
  output logic [NUM_FF-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int i = 0; i < NUM_FF; i++) begin
        if (en[i]) begin
          case ({j[i], k[i]})
            2'b01:   q[i] <= 1'b0;
            2'b10:   q[i] <= 1'b1;
            2'b11:   q[i] <= ~q[i];
            default: q[i] <= q[i];
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing a JK flip-flop bank among requesters; one op per
// ARB/APPLY slot. Optional op counter enabled by defining JKA_OPCOUNT_EN.
module jk_bank_arbiter
  import jka_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_FF  = 8,
  parameter int ADDR_W  = 3,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*2-1:0]      req_op,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_FF-1:0]         q,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id,
  output logic                      addr_err,
`ifdef JKA_OPCOUNT_EN
  output logic [OPCNT_W-1:0]        op_count,
`endif
  output state_t                    dbg_state,
  output logic [ID_W-1:0]           dbg_rr_ptr
);

  // Handshake: a command transfers on a cycle where req_valid[i] & req_ready[i];
  // ready is only ever raised for the single ARB winner, and valid/addr/op must
  // stay stable until then (withdrawing before ready is allowed).

  localparam logic [ADDR_W:0] NUM_FF_L = (ADDR_W+1)'(NUM_FF);

  state_t              state, next_state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ADDR_W-1:0]   cap_addr;
  logic [1:0]          cap_op;
  logic                err_q;
  logic                any_valid;
  logic                take;
  logic [ID_W-1:0]     win_id;
  logic [ADDR_W-1:0]   win_addr;
  logic [1:0]          win_op;
  logic [NUM_FF-1:0]   bank_en;
  logic                apply_ok;

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    any_valid = 1'b0;
    win_id    = '0;
    win_addr  = '0;
    win_op    = OP_HOLD;
    for (int n = 0; n < NUM_REQ; n++) begin
      idx = (int'(rr_ptr) + n) % NUM_REQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        win_id    = ID_W'(idx);
        win_addr  = req_addr[idx*ADDR_W +: ADDR_W];
        win_op    = req_op[idx*2 +: 2];
      end
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    take       = 1'b0;
    case (state)
      ST_ARB: begin
        if (any_valid) begin
          req_ready[win_id] = 1'b1;
          take              = 1'b1;
          next_state        = ST_APPLY;
        end
      end
      ST_APPLY: next_state = ST_ARB;
      default:  next_state = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_ARB;
      rr_ptr   <= '0;
      cap_addr <= '0;
      cap_op   <= OP_HOLD;
      grant_id <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= next_state;
      if (take) begin
        cap_addr <= win_addr;
        cap_op   <= win_op;
        grant_id <= win_id;
        err_q    <= ({1'b0, win_addr} >= NUM_FF_L);
        rr_ptr   <= (win_id == ID_W'(NUM_REQ-1)) ? '0 : win_id + ID_W'(1);
      end
    end
  end

  assign grant_valid = (state == ST_APPLY);
  assign addr_err    = grant_valid & err_q;
  assign apply_ok    = grant_valid & ~err_q;
  assign dbg_state   = state;
  assign dbg_rr_ptr  = rr_ptr;

  always_comb begin
    bank_en = '0;
    for (int i = 0; i < NUM_FF; i++) begin
      bank_en[i] = apply_ok && (cap_addr == ADDR_W'(i));
    end
  end

  jk_bank #(.NUM_FF(NUM_FF)) u_bank (
    .clk (clk),
    .rst (rst),
    .j   ({NUM_FF{cap_op[1]}}),
    .k   ({NUM_FF{cap_op[0]}}),
    .en  (bank_en),
    .q   (q)
  );

`ifdef JKA_OPCOUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (apply_ok && op_count != {OPCNT_W{1'b1}}) begin
      op_count <= op_count + OPCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: a NUM_FF=8 instance plus a NUM_FF=6
// instance sharing the same request inputs for out-of-range address checks.
module tb_jk_bank_arbiter;
  import jka_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [11:0] req_addr = '0;
  logic [7:0]  req_op = '0;

  logic [3:0]  req_ready, req_ready6;
  logic [7:0]  q;
  logic [5:0]  q6;
  logic        grant_valid, grant_valid6;
  logic [1:0]  grant_id, grant_id6;
  logic        addr_err, addr_err6;
  state_t      dbg_state, dbg_state6;
  logic [1:0]  dbg_rr_ptr, dbg_rr_ptr6;
`ifdef JKA_OPCOUNT_EN
  logic [15:0] op_count, op_count6;
`endif

  int checks = 0;
  int errors = 0;
  logic err6_seen;

  always #5 clk = ~clk;

  jk_bank_arbiter #(.NUM_REQ(4), .NUM_FF(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_op(req_op),
    .req_ready(req_ready), .q(q), .grant_valid(grant_valid), .grant_id(grant_id),
    .addr_err(addr_err),
`ifdef JKA_OPCOUNT_EN
    .op_count(op_count),
`endif
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  jk_bank_arbiter #(.NUM_REQ(4), .NUM_FF(6), .ADDR_W(3)) dut6 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_op(req_op),
    .req_ready(req_ready6), .q(q6), .grant_valid(grant_valid6), .grant_id(grant_id6),
    .addr_err(addr_err6),
`ifdef JKA_OPCOUNT_EN
    .op_count(op_count6),
`endif
    .dbg_state(dbg_state6), .dbg_rr_ptr(dbg_rr_ptr6)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_op = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One command from requester id; checks ack, grant and resulting q.
  task automatic issue(input int id, input logic [2:0] a, input logic [1:0] op,
                       input logic [7:0] exp_q);
    logic [3:0] exp_rdy;
    exp_rdy = 4'(1 << id);
    @(negedge clk);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_addr[id*3 +: 3] = a;
    req_op[id*2 +: 2] = op;
    #1;
    checks++;
    if (req_ready !== exp_rdy || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL issue_ready id=%0d ready=%b gv=%b need ready=%b gv=0", id, req_ready, grant_valid, exp_rdy);
    end
    @(negedge clk);
    req_valid = '0;
    err6_seen = addr_err6;
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'(id) || req_ready !== 4'b0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL issue_grant gv=%b id=%0d ready=%b err=%b need gv=1 id=%0d ready=0000 err=0",
               grant_valid, grant_id, req_ready, addr_err, id);
    end
    @(negedge clk);
    checks++;
    if (q !== exp_q) begin
      errors++;
      $display("FAIL issue_q q=%h need %h", q, exp_q);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (q !== 8'h00 || req_ready !== 4'b0 || grant_valid !== 1'b0 || addr_err !== 1'b0 ||
          grant_id !== 2'd0 || dbg_state !== ST_ARB || dbg_rr_ptr !== 2'd0) begin
        errors++;
        $display("FAIL reset_idle q=%h ready=%b gv=%b err=%b id=%0d st=%0d rr=%0d need all zero",
                 q, req_ready, grant_valid, addr_err, grant_id, dbg_state, dbg_rr_ptr);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_set();
    do_reset();
    issue(0, 3'd3, OP_SET, 8'h08);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    do_reset();
    req_valid = 4'b1111;
    req_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    req_op = {OP_TGL, OP_TGL, OP_TGL, OP_TGL};
    for (int s = 0; s < 5; s++) begin
      exp_rdy = 4'(1 << (s % 4));
      if (s == 4) begin
        #1;
        checks++;
        if (q !== 8'h0F) begin
          errors++;
          $display("FAIL rr_q4 q=%h need 0f", q);
        end
      end
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rr_ready slot=%0d ready=%b need %b", s, req_ready, exp_rdy);
      end
      @(negedge clk);
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== 2'(s % 4) || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL rr_grant slot=%0d gv=%b id=%0d ready=%b need gv=1 id=%0d", s, grant_valid, grant_id, req_ready, s % 4);
      end
      if (s == 4) req_valid = '0;
      @(negedge clk);
    end
    checks++;
    if (q !== 8'h0E) begin
      errors++;
      $display("FAIL rr_q5 q=%h need 0e", q);
    end
  endtask

  task automatic test_serialise();
    do_reset();
    issue(1, 3'd5, OP_SET, 8'h20);
    issue(2, 3'd5, OP_TGL, 8'h00);
    issue(3, 3'd5, OP_RST, 8'h00);
    issue(1, 3'd5, OP_SET, 8'h20);
    issue(0, 3'd5, OP_HOLD, 8'h20);
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    req_valid = 4'b0110;
    req_addr = {3'd0, 3'd6, 3'd6, 3'd0};
    req_op = {OP_HOLD, OP_TGL, OP_TGL, OP_HOLD};
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_ready1 ready=%b need 0010", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (q !== 8'h40 || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_first q=%h ready=%b need q=40 ready=0100", q, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (grant_id !== 2'd2 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_grant2 id=%0d gv=%b need id=2 gv=1", grant_id, grant_valid);
    end
    @(negedge clk);
    checks++;
    if (q !== 8'h00) begin
      errors++;
      $display("FAIL b2b_second q=%h need 00", q);
    end
  endtask

  task automatic test_addr_err();
    do_reset();
    issue(0, 3'd1, OP_SET, 8'h02);
    issue(2, 3'd7, OP_SET, 8'h82);
    checks++;
    if (err6_seen !== 1'b1 || q6 !== 6'h02) begin
      errors++;
      $display("FAIL err_addr7 err6=%b q6=%h need err6=1 q6=02", err6_seen, q6);
    end
    issue(1, 3'd6, OP_SET, 8'hC2);
    checks++;
    if (err6_seen !== 1'b1 || q6 !== 6'h02) begin
      errors++;
      $display("FAIL err_addr6 err6=%b q6=%h need err6=1 q6=02", err6_seen, q6);
    end
    issue(3, 3'd5, OP_SET, 8'hE2);
    checks++;
    if (err6_seen !== 1'b0 || q6 !== 6'h22) begin
      errors++;
      $display("FAIL err_addr5 err6=%b q6=%h need err6=0 q6=22", err6_seen, q6);
    end
`ifdef JKA_OPCOUNT_EN
    checks++;
    if (op_count6 !== 16'd2 || op_count !== 16'd4) begin
      errors++;
      $display("FAIL opcount cnt6=%0d cnt=%0d need 2 and 4", op_count6, op_count);
    end
`endif
  endtask

  task automatic test_rst_in_apply();
    logic [7:0] acc;
    do_reset();
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      acc[i] = 1'b1;
      issue(i % 4, 3'(i), OP_SET, acc);
    end
    @(negedge clk);
    req_valid = 4'b0001;
    req_addr[2:0] = 3'd0;
    req_op[1:0] = OP_TGL;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rstap_ready ready=%b need 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    checks++;
    if (grant_valid !== 1'b1 || q !== 8'hFF) begin
      errors++;
      $display("FAIL rstap_apply gv=%b q=%h need gv=1 q=ff", grant_valid, q);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (q !== 8'h00 || dbg_state !== ST_ARB || dbg_rr_ptr !== 2'd0 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL rstap_after q=%h st=%0d rr=%0d gv=%b id=%0d need q=00 st=0 rr=0 gv=0 id=0",
               q, dbg_state, dbg_rr_ptr, grant_valid, grant_id);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q !== 8'h00 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstap_late q=%h gv=%b need q=00 gv=0", q, grant_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_set();
    test_round_robin();
    test_serialise();
    test_back_to_back();
    test_addr_err();
    test_rst_in_apply();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
